// File: rtl/decode_ctrl_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : decode_ctrl_stage
//  Brief    : Registered RV32I decode stage (ID/EX register) with valid/ready
//             handshake, flush, CSR/MRET/illegal decode and a serialisation
//             FSM that drains the pipeline before serialising instructions.
//  Config   : define RV_MEXT_EN to decode the M extension (mul/div/rem);
//             without it those encodings are flagged illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
    parameter int ALU_OP_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                flush,
    input  logic                pipe_empty,
    input  logic                ser_done,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          mask,
    output logic [2:0]          br_type,
    output logic                reg_wr,
    output logic                sel_a,
    output logic                sel_b,
    output logic                rd_en,
    output logic                wr_en,
    output logic [1:0]          wb_sel,
    output logic [1:0]          csr_op,
    output logic                csr_imm,
    output logic                is_mret,
    output logic                illegal,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic [CNT_W-1:0]    ser_stall_cycles
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SER   = 2'd2;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0]  F7_ALT   = 7'b0100000;
    localparam logic [6:0]  F7_MEXT  = 7'b0000001;
    localparam logic [31:0] MRET_ENC = 32'h3020_0073;

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(5'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(5'd6);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(5'd9);
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(5'd10);

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          mask;
        logic [2:0]          br_type;
        logic                reg_wr;
        logic                sel_a;
        logic                sel_b;
        logic                rd_en;
        logic                wr_en;
        logic [1:0]          wb_sel;
        logic [1:0]          csr_op;
        logic                csr_imm;
        logic                is_mret;
        logic                illegal;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    bundle_t    dec;
    logic       dec_ser;
    logic       accept;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    bundle_t          bundle_q, bundle_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Base ALU code for the shared R/I funct3 map (or/and skip the sra slot).
    function automatic logic [ALU_OP_W-1:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b110:  alu_base = ALU_OP_W'(5'd7);
            3'b111:  alu_base = ALU_OP_W'(5'd8);
            default: alu_base = ALU_OP_W'({2'b00, f3});
        endcase
    endfunction

    // Combinational instruction decode; every field starts at zero.
    always_comb begin
        dec     = '0;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        case (opcode)
            OP_R: begin
                if (funct7 == F7_MEXT) begin
`ifdef RV_MEXT_EN
                    dec.alu_op = ALU_OP_W'({2'b10, funct3});
                    dec.reg_wr = 1'b1;
                    dec.sel_a  = 1'b1;
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    dec.reg_wr = 1'b1;
                    dec.sel_a  = 1'b1;
                    dec.alu_op = alu_base(funct3);
                    if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu_op = ALU_SUB;
                    if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
                end
            end
            OP_IMM: begin
                dec.reg_wr = 1'b1;
                dec.sel_a  = 1'b1;
                dec.sel_b  = 1'b1;
                dec.alu_op = alu_base(funct3);
                if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu_op = ALU_SRA;
            end
            OP_LOAD: begin
                dec.reg_wr = 1'b1;
                dec.rd_en  = 1'b1;
                dec.wb_sel = 2'd1;
                dec.mask   = funct3;
                dec.alu_op = ALU_ADD;
            end
            OP_STORE: begin
                dec.wr_en  = 1'b1;
                dec.mask   = funct3;
                dec.alu_op = ALU_ADD;
            end
            OP_BRANCH: begin
                dec.sel_b   = 1'b1;
                dec.br_type = funct3;
                dec.alu_op  = ALU_ADD;
            end
            OP_LUI: begin
                dec.reg_wr = 1'b1;
                dec.sel_b  = 1'b1;
                dec.alu_op = ALU_PASS_B;
            end
            OP_AUIPC: begin
                dec.reg_wr = 1'b1;
                dec.sel_b  = 1'b1;
                dec.alu_op = ALU_ADD;
            end
            OP_JAL: begin
                dec.reg_wr = 1'b1;
                dec.sel_b  = 1'b1;
                dec.wb_sel = 2'd2;
            end
            OP_JALR: begin
                dec.reg_wr = 1'b1;
                dec.sel_a  = 1'b1;
                dec.sel_b  = 1'b1;
                dec.wb_sel = 2'd2;
            end
            OP_SYSTEM: begin
                // funct3[1:0] is the CSR op, funct3[2] selects the zimm source.
                if (funct3[1:0] != 2'b00) begin
                    dec.csr_op  = funct3[1:0];
                    dec.csr_imm = funct3[2];
                    dec.reg_wr  = 1'b1;
                    dec.wb_sel  = 2'd3;
                end else if (instr == MRET_ENC) begin
                    dec.is_mret = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal instruction must never touch the register file or memory.
        if (dec.illegal) begin
            dec.reg_wr = 1'b0;
            dec.rd_en  = 1'b0;
            dec.wr_en  = 1'b0;
        end
    end

    assign dec_ser = (dec.csr_op != 2'b00) | dec.is_mret | dec.illegal;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM output: in_ready. Serialising instructions wait for an empty pipe and an empty output register.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_RUN: begin
                    if (in_valid && dec_ser) in_ready = pipe_empty && !out_valid_q;
                    else                     in_ready = !out_valid_q || out_ready;
                end
                ST_DRAIN: in_ready = pipe_empty && !out_valid_q;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    // FSM next-state; flush overrides everything, ser_done only matters in SER.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (in_valid && dec_ser) state_d = in_ready ? ST_SER : ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (accept) state_d = dec_ser ? ST_SER : ST_RUN;
                end
                ST_SER: begin
                    if (ser_done) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Output register and saturating stall counter next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((state_q == ST_DRAIN || state_q == ST_SER) && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ID/EX register and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign alu_op           = bundle_q.alu_op;
    assign mask             = bundle_q.mask;
    assign br_type          = bundle_q.br_type;
    assign reg_wr           = bundle_q.reg_wr;
    assign sel_a            = bundle_q.sel_a;
    assign sel_b            = bundle_q.sel_b;
    assign rd_en            = bundle_q.rd_en;
    assign wr_en            = bundle_q.wr_en;
    assign wb_sel           = bundle_q.wb_sel;
    assign csr_op           = bundle_q.csr_op;
    assign csr_imm          = bundle_q.csr_imm;
    assign is_mret          = bundle_q.is_mret;
    assign illegal          = bundle_q.illegal;
    assign rd               = bundle_q.rd;
    assign rs1              = bundle_q.rs1;
    assign rs2              = bundle_q.rs2;
    assign ser_stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_decode_ctrl_stage
//  Brief    : Self-checking bench for decode_ctrl_stage. Expected bundles are
//             queued at accept time from an independent decode model and
//             compared when the stage hands them downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_stage;

    localparam int ALU_OP_W = 5;
    localparam int CNT_W    = 16;

    localparam logic [31:0] I_ADD    = 32'h003100B3;
    localparam logic [31:0] I_SUB    = 32'h403100B3;
    localparam logic [31:0] I_ADDI   = 32'h00730293;
    localparam logic [31:0] I_SLLI   = 32'h00341393;
    localparam logic [31:0] I_CSRRW  = 32'h34029073;
    localparam logic [31:0] I_CSRRSI = 32'h3002E0F3;
    localparam logic [31:0] I_MRET   = 32'h30200073;
    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_BADOP  = 32'h0000007F;
    localparam logic [31:0] I_MUL    = 32'h023100B3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, pipe_empty = 1'b1, ser_done = 1'b0;
    logic in_ready, out_valid;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0] mask, br_type;
    logic reg_wr, sel_a, sel_b, rd_en, wr_en, csr_imm, is_mret, illegal;
    logic [1:0] wb_sel, csr_op;
    logic [4:0] rd, rs1, rs2;
    logic [CNT_W-1:0] ser_stall_cycles;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .pipe_empty(pipe_empty),
        .ser_done(ser_done), .alu_op(alu_op), .mask(mask), .br_type(br_type), .reg_wr(reg_wr),
        .sel_a(sel_a), .sel_b(sel_b), .rd_en(rd_en), .wr_en(wr_en), .wb_sel(wb_sel),
        .csr_op(csr_op), .csr_imm(csr_imm), .is_mret(is_mret), .illegal(illegal),
        .rd(rd), .rs1(rs1), .rs2(rs2), .ser_stall_cycles(ser_stall_cycles)
    );

    wire [37:0] obs = {alu_op, mask, br_type, reg_wr, sel_a, sel_b, rd_en, wr_en,
                       wb_sel, csr_op, csr_imm, is_mret, illegal, rd, rs1, rs2};

    int n_checks = 0;
    int n_pass   = 0;
    logic [37:0] sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Reference decode, written from the instruction-class table.
    function automatic logic [37:0] model(input logic [31:0] i);
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        logic [4:0] a = 5'd0;
        logic [2:0] m = 3'd0, b = 3'd0;
        logic rw = 0, sa = 0, sbb = 0, re = 0, we = 0, ci = 0, mr = 0, il = 0;
        logic [1:0] wb = 2'd0, co = 2'd0;
        logic [4:0] base = (f3 >= 3'd6) ? 5'(f3) + 5'd1 : 5'(f3);
        if (op == 7'h33) begin
            if (f7 == 7'h01) begin
`ifdef RV_MEXT_EN
                a = 5'd16 + 5'(f3); rw = 1; sa = 1;
`else
                il = 1;
`endif
            end else begin
                rw = 1; sa = 1; a = base;
                if (f7 == 7'h20 && f3 == 3'd0) a = 5'd9;
                if (f7 == 7'h20 && f3 == 3'd5) a = 5'd6;
            end
        end else if (op == 7'h13) begin
            rw = 1; sa = 1; sbb = 1; a = base;
            if (f7 == 7'h20 && f3 == 3'd5) a = 5'd6;
        end else if (op == 7'h03) begin
            rw = 1; re = 1; wb = 2'd1; m = f3;
        end else if (op == 7'h23) begin
            we = 1; m = f3;
        end else if (op == 7'h63) begin
            sbb = 1; b = f3;
        end else if (op == 7'h37) begin
            rw = 1; sbb = 1; a = 5'd10;
        end else if (op == 7'h17) begin
            rw = 1; sbb = 1;
        end else if (op == 7'h6F) begin
            rw = 1; sbb = 1; wb = 2'd2;
        end else if (op == 7'h67) begin
            rw = 1; sa = 1; sbb = 1; wb = 2'd2;
        end else if (op == 7'h73) begin
            if (f3[1:0] != 2'd0) begin
                co = f3[1:0]; ci = f3[2]; rw = 1; wb = 2'd3;
            end else if (i == 32'h30200073) mr = 1;
            else il = 1;
        end else begin
            il = 1;
        end
        return {a, m, b, rw, sa, sbb, re, we, wb, co, ci, mr, il, i[11:7], i[19:15], i[24:20]};
    endfunction

    function automatic bit is_ser(input logic [37:0] e);
        return (e[19:18] != 2'd0) || e[16] || e[15];
    endfunction

    // One clock: observe handshakes at the falling edge, then land 1ns after the rising edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (flush) sb.delete();
        else if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
            else chk("bundle", 64'(obs), 64'(sb.pop_front()));
        end
        if (acc) sb.push_back(model(instr));
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction with out_ready high; completes serialisation if needed.
    task automatic issue(input logic [31:0] ins);
        bit ok = 0;
        bit d;
        in_valid = 1'b1;
        instr    = ins;
        for (int k = 0; k < 20 && !ok; k++) step(ok);
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
        step(d);
        if (is_ser(model(ins))) begin
            ser_done = 1'b1;
            step(d);
            ser_done = 1'b0;
            chk("ser_back_to_run", 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit a;
        logic [31:0] mix [8] = '{32'h40255493, 32'h00812083, 32'h00312223, 32'h00208463,
                                 32'h123452B7, 32'h00001317, 32'h010000EF, 32'h00008067};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_bundle", 64'(obs), 64'(0));
        chk("rst_cnt", 64'(ser_stall_cycles), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back add then sub
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = I_ADD;
        step(a);
        chk("add_acc", 64'(a), 64'(1));
        chk("add_valid", 64'(out_valid), 64'(1));
        chk("add_op", 64'(alu_op), 64'(0));
        chk("add_regwr", 64'(reg_wr), 64'(1));
        instr = I_SUB;
        step(a);
        chk("sub_acc", 64'(a), 64'(1));
        chk("sub_valid", 64'(out_valid), 64'(1));
        chk("sub_op", 64'(alu_op), 64'(9));
        in_valid = 1'b0;
        step(a);
        chk("b2b_drained", 64'(out_valid), 64'(0));

        // Downstream stall: bundle must hold, no further accept
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = I_ADDI;
        step(a);
        chk("stall_first_acc", 64'(a), 64'(1));
        instr = I_SLLI;
        for (int k = 0; k < 3; k++) begin
            step(a);
            chk("stall_in_ready", 64'(a), 64'(0));
            chk("stall_hold", 64'(obs), 64'(model(I_ADDI)));
            chk("stall_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        step(a);
        chk("stall_release_acc", 64'(a), 64'(1));
        in_valid = 1'b0;
        step(a);

        // Assorted instruction classes through the scoreboard
        foreach (mix[k]) issue(mix[k]);

        // csrrw held in DRAIN for 4 cycles, then SER for 4 cycles
        pipe_empty = 1'b0;
        in_valid   = 1'b1;
        instr      = I_CSRRW;
        for (int k = 0; k < 4; k++) begin
            step(a);
            chk("drain_in_ready", 64'(a), 64'(0));
        end
        pipe_empty = 1'b1;
        step(a);
        chk("drain_acc", 64'(a), 64'(1));
        chk("csr_op", 64'(csr_op), 64'(1));
        chk("csr_wb_sel", 64'(wb_sel), 64'(3));
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(a);
            chk("ser_in_ready", 64'(in_ready), 64'(0));
        end
        ser_done = 1'b1;
        step(a);
        ser_done = 1'b0;
        chk("ser_exit_ready", 64'(in_ready), 64'(1));
        chk("stall_cnt_csr", 64'(ser_stall_cycles), 64'(8));

        // ser_done in RUN is ignored
        ser_done = 1'b1;
        step(a);
        ser_done = 1'b0;
        chk("done_in_run_cnt", 64'(ser_stall_cycles), 64'(8));
        chk("done_in_run_rdy", 64'(in_ready), 64'(1));

        // Illegal opcode enters SER; flush aborts it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = I_BADOP;
        step(a);
        in_valid = 1'b0;
        chk("illegal_acc", 64'(a), 64'(1));
        chk("illegal_flag", 64'(illegal), 64'(1));
        chk("illegal_enables", 64'({reg_wr, wr_en, rd_en}), 64'(0));
        step(a);
        chk("illegal_ser_rdy", 64'(in_ready), 64'(0));
        chk("illegal_held", 64'(out_valid), 64'(1));
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'(0));
        step(a);
        flush = 1'b0;
        #1;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_run_rdy", 64'(in_ready), 64'(1));
        chk("stall_cnt_flush", 64'(ser_stall_cycles), 64'(10));

        // More serialising encodings
        out_ready = 1'b1;
        issue(I_CSRRSI);
        issue(I_MRET);
        issue(I_ECALL);

        // M-extension encoding
        in_valid = 1'b1;
        instr    = I_MUL;
        step(a);
        in_valid = 1'b0;
        chk("mul_acc", 64'(a), 64'(1));
`ifdef RV_MEXT_EN
        chk("mul_op", 64'(alu_op), 64'(16));
`else
        chk("mul_illegal", 64'(illegal), 64'(1));
`endif
        step(a);
        ser_done = 1'b1;
        step(a);
        ser_done = 1'b0;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = I_ADD;
        step(a);
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_bundle", 64'(obs), 64'(0));
        chk("mid_rst_cnt", 64'(ser_stall_cycles), 64'(0));
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
